// File: rtl/wavelet_row_packer.sv
// wavelet_row_packer: collects the (s, d) coefficient pairs that row_processor
// emits and rebuilds each row as [s0..s(N/2-1), d0..d(N/2-1)]. Rows are then
// streamed out one byte at a time over valid/ready. Two row banks alternate,
// so the next row can be captured while the previous one drains.
module wavelet_row_packer #(
  parameter int LENGTH = 256,
  parameter int WIDTH  = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             result,
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             row_done,
  output logic             overflow,
  output logic [15:0]      rows_out
);

  localparam int IDX_W = $clog2(LENGTH);
  localparam int HALF  = LENGTH / 2;
  localparam logic [IDX_W-1:0] WR_LAST = IDX_W'(HALF - 1);
  localparam logic [IDX_W-1:0] RD_LAST = IDX_W'(LENGTH - 1);

  // Two row banks; bank index is the first dimension.
  logic [WIDTH-1:0] mem [2][LENGTH];

  logic [1:0]       full;
  logic [1:0]       full_nxt;
  logic             wr_bank;
  logic             rd_bank;
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] wr_hi;
  logic [IDX_W-1:0] rd_idx;
  logic             wr_en;
  logic             wr_end;
  logic             rd_xfer;
  logic             rd_end;

  // The read side is purely combinational from the bank flags, the read
  // index and the buffer; nothing on it waits for a register stage.
  assign out_valid = full[rd_bank];
  assign out_data  = mem[rd_bank][rd_idx];
  assign out_last  = out_valid && (rd_idx == RD_LAST);

  // Detail coefficients land in the upper half of the row.
  assign wr_hi = wr_idx + IDX_W'(HALF);

  // Decode this cycle's write/read events and the resulting bank flags.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    wr_en    = result && !full[wr_bank];
    wr_end   = wr_en && (wr_idx == WR_LAST);
    rd_xfer  = out_valid && out_ready;
    rd_end   = rd_xfer && (rd_idx == RD_LAST);
    full_nxt = full;
    // A completing write and a completing read always target different
    // banks (one must be empty, the other full), so both updates apply.
    if (rd_end) full_nxt[rd_bank] = 1'b0;
    if (wr_end) full_nxt[wr_bank] = 1'b1;
  end

  // Row storage: scatter each pair into its s and d slots.
  always_ff @(posedge clk) begin
    // NOTE: the buffer is deliberately not reset; the full flags alone decide
    // whether its contents are ever observed, and leaving it out of reset
    // keeps it mappable onto plain RAM.
    if (wr_en) begin
      mem[wr_bank][wr_idx] <= s;
      mem[wr_bank][wr_hi]  <= d;
    end
  end

  // Bank/index bookkeeping, status flags and the drained-row counter.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // here sees pre-edge values, e.g. full[] is sampled before a same-cycle
    // read frees a bank, which is what makes that pair count as dropped.
    if (!resetn) begin
      full     <= '0;
      wr_bank  <= 1'b0;
      rd_bank  <= 1'b0;
      wr_idx   <= '0;
      rd_idx   <= '0;
      row_done <= 1'b0;
      overflow <= 1'b0;
      rows_out <= '0;
    end else begin
      full     <= full_nxt;
      row_done <= wr_end;
      if (result && full[wr_bank]) overflow <= 1'b1;
      if (wr_en) begin
        if (wr_end) begin
          wr_idx  <= '0;
          wr_bank <= ~wr_bank;
        end else begin
          wr_idx  <= wr_idx + IDX_W'(1);
        end
      end
      if (rd_xfer) begin
        if (rd_end) begin
          rd_idx   <= '0;
          rd_bank  <= ~rd_bank;
          rows_out <= rows_out + 16'd1;
        end else begin
          rd_idx   <= rd_idx + IDX_W'(1);
        end
      end
    end
  end

endmodule
